os_array_feeder: RTL and testbench

OS_ARRAY_FEEDER -- requirements
Module: os_array_feeder

---
 rtl/os_array_feeder_if.sv | 28 ++
 rtl/os_array_feeder.sv | 185 ++++++++++++++++++
 tb/tb_os_array_feeder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/os_array_feeder_if.sv
// rtl/os_array_feeder_if.sv - tile control, operand beat and skewed edge-feed bundle for os_array_feeder
interface os_array_feeder_if #(
  parameter int N = 4
);
  logic           start;
  logic [7:0]     k_len;
  logic           src_valid;
  logic           src_ready;
  logic [N*8-1:0] src_a;
  logic [N*8-1:0] src_b;
  logic [N*8-1:0] a_row;
  logic [N*8-1:0] b_col;
  logic           compute_en;
  logic           busy;
  logic           done;
  logic           result_ack;
  logic [15:0]    stall_cnt;

  modport master (
    output start, k_len, src_valid, src_a, src_b, result_ack,
    input  src_ready, a_row, b_col, compute_en, busy, done, stall_cnt
  );

  modport slave (
    input  start, k_len, src_valid, src_a, src_b, result_ack,
    output src_ready, a_row, b_col, compute_en, busy, done, stall_cnt
  );
endinterface

// File: rtl/os_array_feeder.sv
// rtl/os_array_feeder.sv - skewed operand feeder and tile sequencer for an NxN output-stationary array
// Optional FEED-stall counter is built only when FEEDER_STALL_CNT_EN is defined.
module os_array_feeder #(
  parameter int N         = 4,
  parameter int DRAIN_CYC = 2 * N
) (
  input  logic              clk,
  input  logic              rst_n,
  os_array_feeder_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  logic [2:0]     state_q, state_d;
  logic [7:0]     k_len_q, k_len_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
  logic           src_ready_q, src_ready_d;
  logic           compute_en_q, compute_en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N*8-1:0] in_a_q, in_a_d;
  logic [N*8-1:0] in_b_q, in_b_d;
  logic [N*8-1:0] a_row_w;
  logic [N*8-1:0] b_col_w;
  logic           accept;
  logic           chain_run;

  assign accept    = bus.src_valid & src_ready_q;
  assign chain_run = (state_q == S_FEED) || (state_q == S_DRAIN);

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.k_len != 8'd0)) begin
          state_d    = S_FEED;
          k_len_d    = bus.k_len;
          beat_cnt_d = 8'd0;
        end
      end
      S_FEED: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_d == k_len_q) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
          state_d = S_HOLD;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_HOLD: begin
        if (bus.result_ack) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every one of them is a flop.
  always_comb begin
    src_ready_d  = (state_d == S_FEED) && (beat_cnt_d < k_len_d);
    compute_en_d = (state_d == S_FEED) || (state_d == S_DRAIN) || (state_d == S_HOLD);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_HOLD);
    in_a_d       = accept ? bus.src_a : '0;
    in_b_d       = accept ? bus.src_b : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_len_q      <= 8'd0;
      beat_cnt_q   <= 8'd0;
      drain_cnt_q  <= '0;
      src_ready_q  <= 1'b0;
      compute_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in_a_q       <= '0;
      in_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      k_len_q      <= k_len_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      src_ready_q  <= src_ready_d;
      compute_en_q <= compute_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
    end
  end

  // Lane g gets g+1 stages after the capture register, so a beat accepted at
  // edge t reaches lane g of the edge feed at edge t+1+g.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [7:0] a_pipe_q [0:g];
    logic [7:0] a_pipe_d [0:g];
    logic [7:0] b_pipe_q [0:g];
    logic [7:0] b_pipe_d [0:g];

    always_comb begin
      for (int d = 0; d <= g; d++) begin
        a_pipe_d[d] = 8'd0;
        b_pipe_d[d] = 8'd0;
      end
      if (chain_run) begin
        a_pipe_d[0] = in_a_q[g*8 +: 8];
        b_pipe_d[0] = in_b_q[g*8 +: 8];
        for (int d = 1; d <= g; d++) begin
          a_pipe_d[d] = a_pipe_q[d-1];
          b_pipe_d[d] = b_pipe_q[d-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= g; d++) begin
          a_pipe_q[d] <= 8'd0;
          b_pipe_q[d] <= 8'd0;
        end
      end else begin
        for (int d = 0; d <= g; d++) begin
          a_pipe_q[d] <= a_pipe_d[d];
          b_pipe_q[d] <= b_pipe_d[d];
        end
      end
    end

    assign a_row_w[g*8 +: 8] = a_pipe_q[g];
    assign b_col_w[g*8 +: 8] = b_pipe_q[g];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && (state_d == S_FEED)) begin
      stall_cnt_d = 16'd0;
    end else if ((state_q == S_FEED) && !bus.src_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

  assign bus.src_ready  = src_ready_q;
  assign bus.compute_en = compute_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.a_row      = a_row_w;
  assign bus.b_col      = b_col_w;

endmodule

// File: tb/tb_os_array_feeder.sv
// tb/tb_os_array_feeder.sv - directed bench for os_array_feeder with a tile-level reference and PE array model
module tb_os_array_feeder;
  localparam int N  = 4;
  localparam int DC = 2 * N;

  logic clk;
  logic rst_n;
  os_array_feeder_if #(.N(N)) bus();

  os_array_feeder #(.N(N), .DRAIN_CYC(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int lane(input logic [N*8-1:0] v, input int i);
    logic signed [7:0] x;
    x = v[i*8 +: 8];
    return int'(x);
  endfunction

  // Tile-level reference: phase, beats accepted, and a history of accepted beats.
  int mst, mk, nacc, dcnt, mstall;
  logic macc, mready, mce, mbusy, mdone;
  logic [N*8-1:0] ha [0:15];
  logic [N*8-1:0] hb [0:15];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst = 0; mk = 0; nacc = 0; dcnt = 0; mstall = 0;
      for (int i = 0; i < 16; i++) begin ha[i] = '0; hb[i] = '0; end
    end else begin
      macc = bus.src_valid && mready;
      for (int i = 15; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
      ha[0] = macc ? bus.src_a : '0;
      hb[0] = macc ? bus.src_b : '0;
      case (mst)
        0: if (bus.start && bus.k_len != 8'd0) begin mst = 1; mk = bus.k_len; nacc = 0; mstall = 0; end
        1: begin
          if (!bus.src_valid && mstall < 65535) mstall++;
          if (macc) nacc++;
          if (nacc == mk) begin mst = 2; dcnt = 0; end
        end
        2: begin dcnt++; if (dcnt == DC) mst = 3; end
        3: if (bus.result_ack) mst = 4;
        default: mst = 0;
      endcase
    end
    mready = (mst == 1) && (nacc < mk);
    mce    = (mst == 1) || (mst == 2) || (mst == 3);
    mbusy  = (mst != 0);
    mdone  = (mst == 3);
  end

  function automatic logic [N*8-1:0] exp_feed(input bit is_b);
    logic [N*8-1:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = is_b ? hb[1+i][i*8 +: 8] : ha[1+i][i*8 +: 8];
    return r;
  endfunction

  // Output-stationary array fed from the DUT edges: PE(i,j) sees row i delayed j, column j delayed i.
  logic [N*8-1:0] aobs [0:15];
  logic [N*8-1:0] bobs [0:15];
  int pe [N][N];

  always @(negedge clk) begin
    chk("src_ready", bus.src_ready, mready);
    chk("compute_en", bus.compute_en, mce);
    chk("busy", bus.busy, mbusy);
    chk("done", bus.done, mdone);
    chk("a_row", bus.a_row, exp_feed(1'b0));
    chk("b_col", bus.b_col, exp_feed(1'b1));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, mstall);
`else
    chk("stall_cnt", bus.stall_cnt, 0);
`endif
    for (int i = 15; i > 0; i--) begin aobs[i] = aobs[i-1]; bobs[i] = bobs[i-1]; end
    aobs[0] = bus.a_row;
    bobs[0] = bus.b_col;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        pe[i][j] = bus.compute_en ? pe[i][j] + lane(aobs[j], i) * lane(bobs[i], j) : 0;
  end

  logic [N*8-1:0] ta [0:7];
  logic [N*8-1:0] tbb [0:7];

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic ack_tile;
    bus.result_ack = 1'b1;
    tick;
    bus.result_ack = 1'b0;
    chk("clear_compute_en", bus.compute_en, 0);
    chk("clear_busy", bus.busy, 1);
    tick;
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic run_tile(input int k, input int stall_at, input int stall_n, input bit poke,
                          input int exp_en, input int lit11, input int lit12);
    int b, s, guard, en_cnt, e;
    logic acc;
    b = 0; s = 0; guard = 0; en_cnt = 0;
    bus.start = 1'b1; bus.k_len = 8'(k);
    tick;
    bus.start = 1'b0;
    while (b < k && guard < 200) begin
      if (bus.compute_en && !bus.done) en_cnt++;
      if (b == stall_at && s < stall_n) begin
        bus.src_valid = 1'b0; s++;
      end else begin
        bus.src_valid = 1'b1; bus.src_a = ta[b]; bus.src_b = tbb[b];
      end
      bus.start = poke && (b == 0);
      bus.k_len = poke ? 8'd5 : 8'(k);
      acc = bus.src_valid && bus.src_ready;
      tick;
      if (acc) b++;
      guard++;
    end
    bus.src_valid = 1'b0; bus.start = 1'b0; bus.k_len = 8'(k);
    chk("ready_after_last_beat", bus.src_ready, 0);
    while (!bus.done && guard < 200) begin
      if (bus.compute_en) en_cnt++;
      tick;
      guard++;
    end
    chk("done_reached", bus.done, 1);
    chk("compute_en_cycles", en_cnt, exp_en);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt_tile", bus.stall_cnt, stall_n);
`else
    chk("stall_cnt_tile", bus.stall_cnt, 0);
`endif
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e = 0;
        for (int q = 0; q < k; q++) e += lane(ta[q], i) * lane(tbb[q], j);
        chk($sformatf("pe_%0d_%0d", i, j), pe[i][j], e);
      end
    chk("pe_1_1_literal", pe[1][1], lit11);
    chk("pe_1_2_literal", pe[1][2], lit12);
    ack_tile;
  endtask

  initial begin
    int dcount;
    clk = 1'b0; rst_n = 1'b0;
    bus.start = 1'b0; bus.k_len = 8'd0; bus.src_valid = 1'b0;
    bus.src_a = '0; bus.src_b = '0; bus.result_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin aobs[i] = '0; bobs[i] = '0; end
    tick; tick;
    chk("reset_busy", bus.busy, 0);
    chk("reset_a_row", bus.a_row, 0);
    rst_n = 1'b1;
    tick;

    for (int q = 0; q < 4; q++) begin ta[q] = 32'h1 << (8*q); tbb[q] = 32'h1 << (8*q); end
    run_tile(4, 99, 0, 1'b0, 12, 1, 0);
    run_tile(4, 2, 3, 1'b0, 15, 1, 0);

    ta[0] = 32'h7F7F7F7F; ta[1] = 32'h7F7F7F7F;
    tbb[0] = 32'h80808080; tbb[1] = 32'h80808080;
    run_tile(2, 99, 0, 1'b0, 10, -32512, -32512);

    ta[0] = 32'h01FF0280; ta[1] = 32'h7F03FE05;
    tbb[0] = 32'h10200304; tbb[1] = 32'h01020506;
    run_tile(2, 99, 0, 1'b1, 10, -4, 60);

    bus.start = 1'b1; bus.k_len = 8'd1; bus.src_valid = 1'b1;
    bus.src_a = 32'h04030201; bus.src_b = 32'h0;
    tick;
    bus.start = 1'b0;
    tick;
    bus.src_valid = 1'b0;
    chk("skew_t0", bus.a_row, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("skew_lane%0d", i), bus.a_row, 32'(i + 1) << (8*i));
    end
    tick;
    chk("skew_after", bus.a_row, 0);
    dcount = 0;
    while (!bus.done && dcount < 50) begin tick; dcount++; end
    chk("skew_done", bus.done, 1);
    ack_tile;

    bus.start = 1'b1; bus.k_len = 8'd0;
    tick;
    bus.start = 1'b0;
    chk("k0_ignored", bus.busy, 0);
    tick;
    chk("k0_still_idle", bus.busy, 0);

    bus.start = 1'b1; bus.k_len = 8'd2; bus.src_valid = 1'b1;
    bus.src_a = 32'h11223344; bus.src_b = 32'h55667788;
    tick;
    bus.start = 1'b0;
    tick; tick;
    bus.src_valid = 1'b0;
    tick; tick; tick;
    chk("drain_busy", bus.busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_compute_en", bus.compute_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_a_row", bus.a_row, 0);
    chk("rst_b_col", bus.b_col, 0);
    chk("rst_src_ready", bus.src_ready, 0);
    tick; tick;
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin tick; if (bus.done) dcount++; end
    chk("no_done_after_reset", dcount, 0);
    chk("idle_after_reset", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
